// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bundle type and carry-update helper for the ALU pipeline.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_INC   = 4'd2;
    localparam logic [3:0] OP_PASSA = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_ADC   = 4'd8;
    localparam logic [3:0] OP_SBC   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_ASR   = 4'd12;
    localparam logic [3:0] OP_DEC   = 4'd13;
    localparam logic [3:0] OP_CMP   = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

    // Pass-through and bitwise ops leave the stored carry alone.
    function automatic logic op_updates_cst(input logic [3:0] op);
        return !((op >= OP_PASSA && op <= OP_NOT) || op == OP_PASSB);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Offer/result bus of the ALU pipeline; the DUT sits on the slave modport.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    // Offer transfers on a rising edge with in_valid && in_ready; result transfers with
    // out_valid && out_ready. A valid side holds its payload stable until the transfer.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             neg;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, c_out, ovf, neg, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, c_out, ovf, neg, zero
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: op decode, shared WIDTH+1 bit adder, shifter and flag logic.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OPW-1:0]   op_i,
    input  logic             cst_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o,
    output logic             cst_we_o
);

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    // Subtraction is a + ~b + cin, so the adder carry-out is already NOT borrow.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        arith   = 1'b0;
        case (op_i)
            OP_ADD:         begin add_b = b_i;  arith = 1'b1; end
            OP_SUB, OP_CMP: begin add_b = ~b_i; add_cin = 1'b1;  arith = 1'b1; end
            OP_INC:         begin add_cin = 1'b1; arith = 1'b1; end
            OP_ADC:         begin add_b = b_i;  add_cin = cst_i; arith = 1'b1; end
            OP_SBC:         begin add_b = ~b_i; add_cin = cst_i; arith = 1'b1; end
            OP_DEC:         begin add_b = '1;   arith = 1'b1; end
            default:        ;
        endcase
    end

    assign sum = {1'b0, a_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op_i)
            OP_PASSA: res = a_i;
            OP_AND:   res = a_i & b_i;
            OP_OR:    res = a_i | b_i;
            OP_XOR:   res = a_i ^ b_i;
            OP_NOT:   res = ~a_i;
            OP_SHL:   begin res = {a_i[WIDTH-2:0], 1'b0};      carry = a_i[WIDTH-1]; end
            OP_SHR:   begin res = {1'b0, a_i[WIDTH-1:1]};      carry = a_i[0]; end
            OP_ASR:   begin res = {a_i[WIDTH-1], a_i[WIDTH-1:1]}; carry = a_i[0]; end
            OP_PASSB: res = b_i;
            default:  ;
        endcase
        if (arith) begin
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
        end
    end

    // Same-sign operands into the adder producing a different-sign result is overflow.
    assign ovf = arith && (a_i[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

    assign result_o = res;
    assign flags_o  = {carry, ovf, res[WIDTH-1], ~|res};
    assign cst_we_o = op_updates_cst(op_i);

endmodule

// File: rtl/alu_pipe.sv
// One-stage ALU pipeline: valid/ready handshake, one-entry result register and stored carry.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    flags_t           flags_q,     flags_d;
    logic             cst_q,       cst_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] core_result;
    flags_t           core_flags;
    logic             core_cst_we;

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .a_i      (bus.a),
        .b_i      (bus.b),
        .op_i     (bus.op),
        .cst_i    (cst_q),
        .result_o (core_result),
        .flags_o  (core_flags),
        .cst_we_o (core_cst_we)
    );

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Carry is written on the same edge as the result, so a back-to-back ADC/SBC sees it.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        cst_d       = cst_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = core_result;
            flags_d     = core_flags;
            if (core_cst_we) begin
                cst_d = core_flags.c_out;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            cst_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            cst_q       <= cst_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.c_out     = flags_q.c_out;
    assign bus.ovf       = flags_q.ovf;
    assign bus.neg       = flags_q.neg;
    assign bus.zero      = flags_q.zero;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have parameter OPW, default 4, opcode width; fixed at 4 for this generation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand/opcode offer valid.
REQ-006 SHALL have port in_ready  output  1  block accepts offer this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands, two's complement or unsigned per op.
REQ-008 SHALL have port op  input  OPW  operation select (REQ-013).
REQ-009 SHALL have port out_valid  output  1  result register holds an undelivered result.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports c_out, ovf, neg, zero  output  1 each  registered flags for result.

Function
REQ-013 SHALL decode op: 0 ADD a+b; 1 SUB a-b; 2 INC a+1; 3 PASS a; 4 AND; 5 OR; 6 XOR; 7 NOT a; 8 ADC a+b+Cst; 9 SBC a-b-!Cst; 10 SHL a<<1; 11 SHR a>>1 logical; 12 ASR a>>>1; 13 DEC a-1; 14 CMP (result=a-b, flags as SUB); 15 PASS b.
REQ-014 SHALL accept an offer when in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry output register, no combinational path from in_valid to out_valid).
REQ-015 SHALL present result and flags of an accepted offer exactly one cycle after acceptance, with out_valid high.
REQ-016 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL, on simultaneous drain and accept, load the new result in the same edge with out_valid staying 1 (full throughput, one op per cycle).
REQ-018 SHALL clear out_valid after a drain with no accept.
REQ-019 SHALL compute arithmetic at WIDTH+1 bits; c_out = bit WIDTH for ADD/INC/ADC; for SUB/SBC/CMP/DEC c_out = NOT borrow.
REQ-020 SHALL set ovf as signed overflow: ADD/ADC when a,b signs equal and result sign differs; SUB/SBC/CMP when a,b signs differ and result sign differs from a; INC only when a = 2^(WIDTH-1)-1; DEC only when a = 2^(WIDTH-1).
REQ-021 SHALL set shifts: SHL c_out = a[WIDTH-1]; SHR/ASR c_out = a[0]; ovf = 0.
REQ-022 SHALL force c_out = 0 and ovf = 0 for ops 3..7 and 15.
REQ-023 SHALL set neg = result[WIDTH-1] and zero = (result == 0) for every op.
REQ-024 SHALL keep a stored carry Cst, updated to the op's c_out on acceptance of ops 0,1,2,8..14 only; ops 3..7,15 leave Cst unchanged.
REQ-025 SHALL use, for ADC/SBC, the Cst value written by the most recent earlier accepted op, including the op accepted the immediately preceding cycle (no bubble).

Reset
REQ-026 SHALL, while rst is high at a clock edge, set out_valid=0, result=0, c_out=0, ovf=0, neg=0, zero=0, Cst=0; in_ready is 1 the cycle after reset.
REQ-027 SHALL discard any undelivered result and ignore any offer presented in a cycle where rst is high (reset mid-operation loses the op).

Structure
REQ-028 SHALL place opcode constants (OP_ADD .. OP_PASSB) and the 4-bit flag bundle type in shared package alu_pkg.
REQ-029 SHALL isolate the combinational datapath (op decode, WIDTH+1 adder, shifter, flags) in sub-module alu_core; alu_pipe holds handshake, output register and Cst.

Verification
REQ-030 Bench SHALL run WIDTH=8: ADD 127+1 -> result 128, ovf 1, neg 1, c_out 0, zero 0, one cycle after accept.
REQ-031 Bench SHALL run SUB 0-1 then SBC 0-0 back-to-back -> 255/c_out 0, then 255 (borrow propagated via Cst), out_valid continuous with out_ready=1.
REQ-032 Bench SHALL hold out_ready=0 for 3 cycles after ADD 200+100 -> result 44, c_out 1 held stable, in_ready 0, second offer not accepted until drain.
REQ-033 Bench SHALL run ADD 255+1 (Cst=1), AND 0xF0&0x0F (result 0, zero 1, c_out 0), ADC 1+1 -> result 3 (Cst preserved across logical op).
REQ-034 Bench SHALL assert rst for one cycle while out_valid=1 with in_valid=1 -> out_valid 0, all flags 0, offer dropped, Cst 0.
REQ-035 Bench SHALL repeat exhaustive random compare against a reference model for WIDTH=8 and WIDTH=16 with random in_valid/out_ready, zero mismatches.
